pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard-detection and operand-forwarding unit for the five-stage pipeline. It keeps its own shadow record of destination registers in EX, MEM and WB, and a scoreboard for one multi-cycle (mul/div) unit. From these it produces:
- the load-use / multi-cycle stall;
- per-read-port ID-stage bypass selects, which cover WB and multi-cycle write-back to any number of read ports;
- registered EX-stage forwarding selects.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NRP, 2, number of ID read ports
- MD_LAT, 4, multi-cycle unit latency in cycles; legal range 3..15

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  an instruction is present in ID
- flush  in  1  the ID instruction is squashed this cycle and is not issued
- id_rs_addr  in  NRP*ADDR_W  source register address per port; port p is bits [p*ADDR_W +: ADDR_W]
- id_rs_used  in  NRP  port p is actually read by the instruction
- id_wr_en  in  1  the ID instruction writes a register
- id_wr_addr  in  ADDR_W  destination register of the ID instruction
- id_is_load  in  1  the ID instruction is a load
- id_is_md  in  1  the ID instruction issues to the multi-cycle unit
- stall  out  1  hold IF/ID and insert a bubble into EX
- id_bypass  out  2*NRP  ID bypass select per port: 00 = regfile, 01 = WB result, 10 = multi-cycle result
- ex_fwd_sel  out  2*NRP  EX operand select per port: 00 = ID/EX value, 01 = EX/MEM result, 10 = MEM/WB result
- md_busy  out  1  the multi-cycle unit holds a pending result
- md_done  out  1  one-cycle pulse; the multi-cycle result is written this cycle

## Operation
- **Stage slots.** EX, MEM and WB each hold {valid, wr_en, addr, is_load}. A slot counts as writing only if valid, wr_en and addr != 0. Register 0 never matches anything.
- **Issue.** The ID instruction issues when id_valid && !flush && !stall.
- **Slot advance.** Every cycle, WB <= MEM and MEM <= EX. EX is loaded with the ID instruction if it issues, otherwise with a bubble (valid = 0). An instruction with id_is_md = 1 never enters EX as a writer; its write is tracked only by the scoreboard.
- **Scoreboard.**
  - The md_cnt counter loads MD_LAT when an md instruction issues, and md_dest captures id_wr_addr at the same time.
  - While md_cnt != 0, md_cnt decrements by 1 every cycle, regardless of stall.
  - md_busy = (md_cnt != 0).
  - md_done is registered: it is 1 in the cycle after md_cnt goes 1 -> 0.
- **stall** is combinational. It is 1 when id_valid && !flush and any of the following holds:
  - (a) Load-use: the EX slot is a writing load and, for some port p, id_rs_used[p] is set and its address equals the EX addr.
  - (b) md RAW: md_busy and some used port matches md_dest (md_dest != 0).
  - (c) md WAW: md_busy and id_wr_en and id_wr_addr == md_dest.
  - (d) Structural: md_busy and id_is_md.
- **id_bypass[p]** is combinational and independent of stall:
  - 10 if md_done and md_dest == rs[p] and rs[p] != 0;
  - else 01 if the WB slot is writing and its addr == rs[p];
  - else 00.
  - Both sources cannot match simultaneously, because of the WAW stall and MD_LAT >= 3.
- **ex_fwd_sel[p]** is registered and captured on the same edge the ID instruction issues. Let s = id_rs_used[p] and a = rs[p]. Priority is newest first:
  - 01 if s and the current EX slot is writing to a and is not a load;
  - else 10 if s and the current MEM slot is writing to a;
  - else 00.
  - On a bubble, ex_fwd_sel is cleared to 0.
- **Widths.** All address compares are ADDR_W bits wide and use exact equality. md_cnt is 4 bits wide.

## Timing
- **Reset** (asynchronous, any cycle, including while md_cnt != 0):
  - all slot valids = 0, md_cnt = 0, md_dest = 0, md_done = 0, ex_fwd_sel = 0;
  - consequently md_busy = 0;
  - stall and id_bypass evaluate to 0 because all slots are empty.
- **Latencies.**
  - stall and id_bypass have 0-cycle latency (combinational).
  - ex_fwd_sel is valid in the cycle the instruction occupies EX.
- **Load-use** costs exactly 1 stall cycle. In the next cycle the load is in MEM, and the dependent instruction issues with ex_fwd_sel = 10.
- **md issue at cycle t:**
  - md_busy is 1 during cycles t+1 .. t+MD_LAT;
  - md_done is 1 at cycle t+MD_LAT+1;
  - a dependent instruction held in ID issues at t+MD_LAT+1 with id_bypass = 10.
- **flush** forces stall = 0 and issues a bubble. An md operation already in progress is not cancelled.
- **Simultaneous load-use and md hazards** produce a single stall; all stall conditions are ORed.

## Test plan
- **Reset state.** Hold rst_n = 0 with arbitrary inputs -> stall = 0, md_busy = 0, md_done = 0, ex_fwd_sel = 0, id_bypass = 0. Assert rst_n = 0 mid-md (md_cnt = 2) -> md_busy drops to 0 immediately and no md_done follows.
- **WB bypass.** Write r5 so it is in the WB slot, with ID reading rs[0] = 5 and rs[1] = 0 -> id_bypass = 01 on port 0 and 00 on port 1. Repeat with a write to r0 -> id_bypass = 00.
- **EX forwarding priority.** Back-to-back ALU writes to r7, then an instruction reading r7 -> ex_fwd_sel = 01. With one unrelated instruction in between -> ex_fwd_sel = 10.
- **Load-use.** lw r3, then add using r3 -> stall = 1 for exactly one cycle, EX gets a bubble, then the add issues with ex_fwd_sel = 10. An instruction reading r3 with id_rs_used = 0 -> no stall.
- **Multi-cycle.** MD_LAT = 4: md into r9 at cycle t, then a reader of r9 -> stall during t+1..t+4, md_done = 1 at t+5, the reader issues at t+5 with id_bypass = 10. A second md or a write to r9 during the busy window -> stall.
- **Flush.** flush = 1 while a load-use condition is present -> stall = 0, a bubble enters EX, and the next cycle's ex_fwd_sel = 0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Hazard detection and operand forwarding for the five-stage
//            pipeline. Tracks destination registers in EX/MEM/WB plus a
//            scoreboard for a single multi-cycle (mul/div) unit, and produces
//            the stall, ID-stage bypass selects and registered EX forwarding
//            selects.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int NRP    = 2,
  parameter int MD_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  flush,
  input  logic [NRP*ADDR_W-1:0] id_rs_addr,
  input  logic [NRP-1:0]        id_rs_used,
  input  logic                  id_wr_en,
  input  logic [ADDR_W-1:0]     id_wr_addr,
  input  logic                  id_is_load,
  input  logic                  id_is_md,
  output logic                  stall,
  output logic [2*NRP-1:0]      id_bypass,
  output logic [2*NRP-1:0]      ex_fwd_sel,
  output logic                  md_busy,
  output logic                  md_done
);

  // Scoreboard counter is 4 bits, which bounds MD_LAT to 15.
  localparam logic [3:0] c_mdLat = 4'(MD_LAT);

  // Shadow slots; MEM and WB only need to know whether they write and where.
  logic              r_exValid, r_exWrEn, r_exLoad;
  logic [ADDR_W-1:0] r_exAddr;
  logic              r_memValid, r_memWrEn;
  logic [ADDR_W-1:0] r_memAddr;
  logic              r_wbValid, r_wbWrEn;
  logic [ADDR_W-1:0] r_wbAddr;

  // Multi-cycle scoreboard
  logic [3:0]        r_mdCnt;
  logic [ADDR_W-1:0] r_mdDest;
  logic              r_mdDone;

  logic [2*NRP-1:0]  r_exFwdSel;
  logic [2*NRP-1:0]  w_fwdNext;
  logic [NRP-1:0]    w_rawHaz;

  logic w_exWriting, w_memWriting, w_wbWriting;
  logic w_mdBusy, w_stall, w_issue, w_mdIssue;

  // A slot only counts as a writer when it is real, writes, and is not r0.
  assign w_exWriting  = r_exValid  && r_exWrEn  && (r_exAddr  != '0);
  assign w_memWriting = r_memValid && r_memWrEn && (r_memAddr != '0);
  assign w_wbWriting  = r_wbValid  && r_wbWrEn  && (r_wbAddr  != '0);

  assign w_mdBusy  = (r_mdCnt != 4'd0);
  assign w_issue   = id_valid && !flush && !w_stall;
  assign w_mdIssue = w_issue && id_is_md;

  // Per read port: RAW hazard, ID bypass select and next EX forwarding select.
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [ADDR_W-1:0] w_rs;
    logic              w_used;
    logic              w_exHit, w_memHit, w_wbHit, w_mdHit;

    assign w_rs   = id_rs_addr[p*ADDR_W +: ADDR_W];
    assign w_used = id_rs_used[p];

    assign w_exHit  = w_exWriting  && (r_exAddr  == w_rs);
    assign w_memHit = w_memWriting && (r_memAddr == w_rs);
    assign w_wbHit  = w_wbWriting  && (r_wbAddr  == w_rs);
    assign w_mdHit  = (r_mdDest != '0) && (r_mdDest == w_rs);

    // Load in EX cannot forward yet; pending md result cannot forward at all.
    assign w_rawHaz[p] = w_used && ((w_exHit && r_exLoad) || (w_mdBusy && w_mdHit));

    // md write-back has priority; both can never hit in the same cycle.
    assign id_bypass[2*p +: 2] = (r_mdDone && w_mdHit) ? 2'b10 :
                                 w_wbHit               ? 2'b01 : 2'b00;

    // Newest producer first: EX/MEM result, then MEM/WB result.
    assign w_fwdNext[2*p +: 2] = (w_used && w_exHit && !r_exLoad) ? 2'b01 :
                                 (w_used && w_memHit)             ? 2'b10 : 2'b00;
  end

  // Combined stall: load-use, md RAW, md WAW and md structural hazards.
  always_comb begin
    w_stall = 1'b0;
    if (id_valid && !flush) begin
      if (|w_rawHaz)                                       w_stall = 1'b1;
      if (w_mdBusy && id_wr_en && (id_wr_addr == r_mdDest)) w_stall = 1'b1;
      if (w_mdBusy && id_is_md)                            w_stall = 1'b1;
    end
  end

  // Advance the shadow pipeline; md instructions enter EX as non-writers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exValid  <= 1'b0;
      r_exWrEn   <= 1'b0;
      r_exLoad   <= 1'b0;
      r_exAddr   <= '0;
      r_memValid <= 1'b0;
      r_memWrEn  <= 1'b0;
      r_memAddr  <= '0;
      r_wbValid  <= 1'b0;
      r_wbWrEn   <= 1'b0;
      r_wbAddr   <= '0;
    end else begin
      r_wbValid  <= r_memValid;
      r_wbWrEn   <= r_memWrEn;
      r_wbAddr   <= r_memAddr;
      r_memValid <= r_exValid;
      r_memWrEn  <= r_exWrEn;
      r_memAddr  <= r_exAddr;
      r_exValid  <= w_issue;
      r_exWrEn   <= w_issue && id_wr_en && !id_is_md;
      r_exLoad   <= w_issue && id_is_load;
      r_exAddr   <= id_wr_addr;
    end
  end

  // Scoreboard: load on md issue, count down unconditionally, pulse on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdCnt  <= 4'd0;
      r_mdDest <= '0;
      r_mdDone <= 1'b0;
    end else begin
      r_mdDone <= (r_mdCnt == 4'd1);
      if (w_mdIssue) begin
        r_mdCnt  <= c_mdLat;
        r_mdDest <= id_wr_addr;
      end else if (w_mdBusy) begin
        r_mdCnt  <= r_mdCnt - 4'd1;
      end
    end
  end

  // Forwarding selects follow the instruction into EX; bubbles carry zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exFwdSel <= '0;
    end else begin
      r_exFwdSel <= w_issue ? w_fwdNext : '0;
    end
  end

  assign stall      = w_stall;
  assign ex_fwd_sel = r_exFwdSel;
  assign md_busy    = w_mdBusy;
  assign md_done    = r_mdDone;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Self-checking bench for pipe_hazard_unit: directed scenarios
//            followed by random traffic, checked against a cycle-history
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;
  localparam int AW  = 5;
  localparam int NRP = 2;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            idValid, flush, idWrEn, idIsLoad, idIsMd;
  logic [NRP*AW-1:0] idRsAddr;
  logic [NRP-1:0]  idRsUsed;
  logic [AW-1:0]   idWrAddr;
  logic            stall, mdBusy, mdDone;
  logic [2*NRP-1:0] idBypass, exFwdSel;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.ADDR_W(AW), .NRP(NRP), .MD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .flush(flush),
    .id_rs_addr(idRsAddr), .id_rs_used(idRsUsed), .id_wr_en(idWrEn),
    .id_wr_addr(idWrAddr), .id_is_load(idIsLoad), .id_is_md(idIsMd),
    .stall(stall), .id_bypass(idBypass), .ex_fwd_sel(exFwdSel),
    .md_busy(mdBusy), .md_done(mdDone)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: history of what entered EX each cycle, plus md issue time.
  typedef struct {
    bit          valid;
    bit          wr;
    logic [4:0]  addr;
    bit          ld;
  } slot_t;

  slot_t      hist[$];
  int         cyc;
  int         mdT;
  logic [4:0] mdDest;
  logic [3:0] expFwd;

  function automatic bit writes(slot_t s);
    return s.valid && s.wr && (s.addr != 0);
  endfunction

  function automatic logic [4:0] rsOf(int p);
    logic [NRP*AW-1:0] v;
    v = idRsAddr;
    return v[p*AW +: AW];
  endfunction

  function automatic bit mBusy();
    return (cyc > mdT) && (cyc <= mdT + LAT);
  endfunction

  function automatic bit mDone();
    return cyc == mdT + LAT + 1;
  endfunction

  function automatic bit mStall();
    slot_t ex;
    bit h;
    ex = hist[hist.size()-1];
    h = 0;
    for (int p = 0; p < NRP; p++) begin
      if (idRsUsed[p] && writes(ex) && ex.ld && rsOf(p) == ex.addr) h = 1;
      if (idRsUsed[p] && mBusy() && mdDest != 0 && rsOf(p) == mdDest) h = 1;
    end
    if (mBusy() && idWrEn && idWrAddr == mdDest) h = 1;
    if (mBusy() && idIsMd) h = 1;
    return idValid && !flush && h;
  endfunction

  function automatic logic [3:0] mBypass();
    logic [3:0] r;
    slot_t wb;
    wb = hist[hist.size()-3];
    r = '0;
    for (int p = 0; p < NRP; p++) begin
      if (mDone() && mdDest == rsOf(p) && rsOf(p) != 0) r[2*p +: 2] = 2'b10;
      else if (writes(wb) && wb.addr == rsOf(p))        r[2*p +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic logic [3:0] mFwdNext();
    logic [3:0] r;
    slot_t ex, mem;
    ex  = hist[hist.size()-1];
    mem = hist[hist.size()-2];
    r = '0;
    for (int p = 0; p < NRP; p++) begin
      if (idRsUsed[p] && writes(ex) && !ex.ld && ex.addr == rsOf(p))  r[2*p +: 2] = 2'b01;
      else if (idRsUsed[p] && writes(mem) && mem.addr == rsOf(p))     r[2*p +: 2] = 2'b10;
    end
    return r;
  endfunction

  task automatic modelReset();
    slot_t b;
    b = '{valid: 0, wr: 0, addr: 0, ld: 0};
    hist.delete();
    repeat (3) hist.push_back(b);
    cyc = 0;
    mdT = -1000;
    mdDest = '0;
    expFwd = '0;
  endtask

  task automatic modelAdvance();
    bit iss;
    logic [3:0] nf;
    slot_t s;
    iss = idValid && !flush && !mStall();
    nf  = iss ? mFwdNext() : 4'b0;
    s.valid = iss;
    s.wr    = iss && idWrEn && !idIsMd;
    s.addr  = idWrAddr;
    s.ld    = idIsLoad;
    if (iss && idIsMd) begin
      mdT = cyc;
      mdDest = idWrAddr;
    end
    hist.push_back(s);
    expFwd = nf;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkAll();
    chk("stall",      32'(stall),    32'(mStall()));
    chk("id_bypass",  32'(idBypass), 32'(mBypass()));
    chk("md_busy",    32'(mdBusy),   32'(mBusy()));
    chk("md_done",    32'(mdDone),   32'(mDone()));
    chk("ex_fwd_sel", 32'(exFwdSel), 32'(expFwd));
  endtask

  task automatic drive(input bit v, input bit fl, input logic [4:0] r0, input logic [4:0] r1,
                       input bit [1:0] used, input bit we, input logic [4:0] wa,
                       input bit ld, input bit md);
    idValid  = v;
    flush    = fl;
    idRsAddr = {r1, r0};
    idRsUsed = used;
    idWrEn   = we;
    idWrAddr = wa;
    idIsLoad = ld;
    idIsMd   = md;
  endtask

  // One pipeline cycle: drive, check against the model, advance the model.
  task automatic step(input bit v, input bit fl, input logic [4:0] r0, input logic [4:0] r1,
                      input bit [1:0] used, input bit we, input logic [4:0] wa,
                      input bit ld, input bit md);
    @(negedge clk);
    drive(v, fl, r0, r1, used, we, wa, ld, md);
    #1;
    checkAll();
    modelAdvance();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic driveRandom();
    drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    checkAll();
    modelAdvance();
  endtask

  initial begin
    // Reset state with arbitrary inputs
    modelReset();
    driveRandom();
    repeat (2) @(negedge clk);
    drive(1, 0, 5'd3, 5'd9, 2'b11, 1, 5'd9, 1, 1);
    #1;
    chk("rst_stall",   32'(stall),    32'd0);
    chk("rst_md_busy", 32'(mdBusy),   32'd0);
    chk("rst_md_done", 32'(mdDone),   32'd0);
    chk("rst_fwd",     32'(exFwdSel), 32'd0);
    chk("rst_bypass",  32'(idBypass), 32'd0);
    releaseReset();

    // WB bypass: r5 reaches WB three cycles after issue
    step(1, 0, 0, 0, 2'b00, 1, 5'd5, 0, 0);
    nop(); nop();
    step(1, 0, 5'd5, 5'd0, 2'b11, 0, 0, 0, 0);
    chk("wb_bypass_r5", 32'(idBypass), 32'b0001);
    step(1, 0, 0, 0, 2'b00, 1, 5'd0, 0, 0);
    nop(); nop();
    step(1, 0, 5'd0, 5'd0, 2'b11, 0, 0, 0, 0);
    chk("wb_bypass_r0", 32'(idBypass), 32'b0000);

    // EX forwarding priority
    step(1, 0, 0, 0, 2'b00, 1, 5'd7, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 5'd7, 0, 0);
    step(1, 0, 5'd7, 5'd0, 2'b01, 0, 0, 0, 0);
    nop();
    chk("fwd_ex", 32'(exFwdSel), 32'b0001);
    step(1, 0, 0, 0, 2'b00, 1, 5'd7, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 5'd2, 0, 0);
    step(1, 0, 5'd7, 5'd0, 2'b01, 0, 0, 0, 0);
    nop();
    chk("fwd_mem", 32'(exFwdSel), 32'b0010);

    // Load-use: exactly one stall, then MEM forwarding
    step(1, 0, 0, 0, 2'b00, 1, 5'd3, 1, 0);
    step(1, 0, 5'd3, 5'd0, 2'b01, 1, 5'd4, 0, 0);
    chk("lu_stall", 32'(stall), 32'd1);
    step(1, 0, 5'd3, 5'd0, 2'b01, 1, 5'd4, 0, 0);
    chk("lu_release", 32'(stall), 32'd0);
    nop();
    chk("lu_fwd", 32'(exFwdSel), 32'b0010);
    step(1, 0, 0, 0, 2'b00, 1, 5'd3, 1, 0);
    step(1, 0, 5'd3, 5'd3, 2'b00, 1, 5'd4, 0, 0);
    chk("lu_unused", 32'(stall), 32'd0);
    nop(); nop();

    // Multi-cycle: reader of r9 held through the busy window
    step(1, 0, 0, 0, 2'b00, 1, 5'd9, 0, 1);
    for (int i = 0; i < LAT; i++) begin
      step(1, 0, 5'd9, 5'd1, 2'b01, 1, 5'd6, 0, 0);
      chk("md_raw_stall", 32'(stall), 32'd1);
    end
    step(1, 0, 5'd9, 5'd1, 2'b01, 1, 5'd6, 0, 0);
    chk("md_done_pulse", 32'(mdDone), 32'd1);
    chk("md_bypass", 32'(idBypass), 32'b0010);
    chk("md_issue", 32'(stall), 32'd0);
    step(1, 0, 0, 0, 2'b00, 1, 5'd9, 0, 1);
    step(1, 0, 0, 0, 2'b00, 1, 5'd10, 0, 1);
    chk("md_struct", 32'(stall), 32'd1);
    step(1, 0, 0, 0, 2'b00, 1, 5'd9, 0, 0);
    chk("md_waw", 32'(stall), 32'd1);
    repeat (4) nop();

    // Flush during a load-use condition
    step(1, 0, 0, 0, 2'b00, 1, 5'd3, 1, 0);
    step(1, 1, 5'd3, 5'd0, 2'b01, 1, 5'd4, 0, 0);
    chk("flush_stall", 32'(stall), 32'd0);
    nop();
    chk("flush_fwd", 32'(exFwdSel), 32'b0000);

    // Asynchronous reset while the md counter sits at 2
    step(1, 0, 0, 0, 2'b00, 1, 5'd11, 0, 1);
    nop(); nop(); nop();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(mdBusy), 32'd0);
    modelReset();
    checkAll();
    repeat (2) @(negedge clk);
    releaseReset();
    repeat (6) begin
      nop();
      chk("rst_mid_done", 32'(mdDone), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      driveRandom();
      #1;
      checkAll();
      modelAdvance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
